// File: rtl/onehot_step_driver_pkg.sv
// Shared types and helpers for the one-hot step driver: position range,
// debounce FSM states and the position-to-decoder-code mapping.
package onehot_step_pkg;

  localparam logic [3:0] POS_LAST = 4'd8;

  typedef enum logic [1:0] {
    DEB_RELEASED,
    DEB_PRESS_WAIT,
    DEB_PRESSED,
    DEB_RELEASE_WAIT
  } deb_state_e;

  // Position 0 blanks the decoder; 1..8 light exactly one input a..h.
  function automatic logic [7:0] pos_to_code(input logic [3:0] pos);
    logic [7:0] code;
    code = 8'h00;
    if (pos != 4'd0 && pos <= POS_LAST) begin
      code = 8'h01 << (pos - 4'd1);
    end
    return code;
  endfunction

endpackage

// File: rtl/onehot_step_driver_if.sv
// Board-side signal bundle: raw buttons/switch in, decoder code and debug position out.
interface onehot_step_driver_if;
  logic       btn_next_n;
  logic       btn_prev_n;
  logic       auto_en;
  logic [7:0] code_out;
  logic [3:0] pos;

  modport master (
    output btn_next_n, btn_prev_n, auto_en,
    input  code_out, pos
  );

  modport slave (
    input  btn_next_n, btn_prev_n, auto_en,
    output code_out, pos
  );
endinterface

// File: rtl/onehot_step_driver_debounce_fsm.sv
// Synchronizes one active-low raw pushbutton and debounces it into a single
// one-cycle pulse per accepted press.
module debounce_fsm
  import onehot_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  // Synchronizer idles at the released (high) level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], btn_n};
  end

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEB_RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        DEB_RELEASED: begin
          if (!btn_s) begin
            state_q <= DEB_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        DEB_PRESS_WAIT: begin
          if (btn_s) begin
            state_q <= DEB_RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DEB_PRESSED;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DEB_PRESSED: begin
          if (btn_s) begin
            state_q <= DEB_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        DEB_RELEASE_WAIT: begin
          if (!btn_s) begin
            state_q <= DEB_PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DEB_RELEASED;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= DEB_RELEASED;
      endcase
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/onehot_step_driver.sv
// Steps a 0..8 selector from debounced buttons or a periodic auto tick and
// drives the matching legal one-hot (or blank) code to the segment decoder.
module onehot_step_driver
  import onehot_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_CYCLES     = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_step_driver_if.slave   bus
);

  localparam int TW = $clog2(AUTO_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_CYCLES - 1);

  logic          next_pulse;
  logic          prev_pulse;
  logic          manual;
  logic [1:0]    auto_sync_q;
  logic          auto_s;
  logic [TW-1:0] tick_cnt_d, tick_cnt_q;
  logic          tick_d, tick_q;
  logic [3:0]    pos_d, pos_q;
  logic [7:0]    code_d, code_q;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (bus.btn_next_n),
    .press_pulse (next_pulse)
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (bus.btn_prev_n),
    .press_pulse (prev_pulse)
  );

  assign auto_s = auto_sync_q[1];
  assign manual = next_pulse | prev_pulse;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    // Manual activity restarts the auto period so a press never doubles up with a tick.
    if (!auto_s || manual) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    pos_d = pos_q;
    if (pos_q > POS_LAST) begin
      pos_d = 4'd0;
    end else if (next_pulse && !prev_pulse) begin
      pos_d = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
    end else if (prev_pulse && !next_pulse) begin
      pos_d = (pos_q == 4'd0) ? POS_LAST : pos_q - 4'd1;
    end else if (!manual && tick_q) begin
      pos_d = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
    end

    code_d = pos_to_code(pos_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_sync_q <= 2'b00;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      pos_q       <= 4'd0;
      code_q      <= 8'h00;
    end else begin
      auto_sync_q <= {auto_sync_q[0], bus.auto_en};
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      pos_q       <= pos_d;
      code_q      <= code_d;
    end
  end

  assign bus.code_out = code_q;
  assign bus.pos      = pos_q;

endmodule

// File: tb/tb_onehot_step_driver.sv
// Directed bench for onehot_step_driver with DEBOUNCE_CYCLES=4, AUTO_CYCLES=16.
module tb_onehot_step_driver;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  onehot_step_driver_if ifc ();

  onehot_step_driver #(.DEBOUNCE_CYCLES(4), .AUTO_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.btn_next_n = 1'b1;
    ifc.btn_prev_n = 1'b1;
    ifc.auto_en    = 1'b0;
    wait_clks(2);
    rst = 1'b0;
  endtask

  task automatic press(input bit nxt, input bit prv, input int hold);
    if (nxt) ifc.btn_next_n = 1'b0;
    if (prv) ifc.btn_prev_n = 1'b0;
    wait_clks(hold);
    ifc.btn_next_n = 1'b1;
    ifc.btn_prev_n = 1'b1;
    wait_clks(12);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (ifc.code_out !== 8'h00 || ifc.pos !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: code=%h pos=%0d required code=00 pos=0", ifc.code_out, ifc.pos);
    end
    for (int e = 0; e < 50; e++) begin
      step_clk();
      n_cmp++;
      if (ifc.code_out !== 8'h00 || ifc.pos !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_idle e=%0d: code=%h pos=%0d required code=00 pos=0", e, ifc.code_out, ifc.pos);
      end
    end
  endtask

  task automatic test_hold_next();
    logic [7:0] exp;
    ifc.btn_next_n = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step_clk();
      exp = (e >= 7) ? 8'h01 : 8'h00;
      n_cmp++;
      if (ifc.code_out !== exp || ifc.pos !== ((e >= 7) ? 4'd1 : 4'd0)) begin
        n_bad++;
        $display("FAIL hold_next e=%0d: code=%h pos=%0d required code=%h", e, ifc.code_out, ifc.pos, exp);
      end
    end
    ifc.btn_next_n = 1'b1;
    wait_clks(12);
    n_cmp++;
    if (ifc.code_out !== 8'h01 || ifc.pos !== 4'd1) begin
      n_bad++;
      $display("FAIL hold_next_single: code=%h pos=%0d required code=01 pos=1", ifc.code_out, ifc.pos);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp;
    for (int b = 0; b < 3; b++) begin
      ifc.btn_next_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (k == 2) ifc.btn_next_n = 1'b1;
        step_clk();
        n_cmp++;
        if (ifc.code_out !== 8'h01) begin
          n_bad++;
          $display("FAIL bounce_phase b=%0d k=%0d: code=%h required 01", b, k, ifc.code_out);
        end
      end
    end
    ifc.btn_next_n = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step_clk();
      exp = (e >= 7) ? 8'h02 : 8'h01;
      n_cmp++;
      if (ifc.code_out !== exp) begin
        n_bad++;
        $display("FAIL bounce_final e=%0d: code=%h required %h", e, ifc.code_out, exp);
      end
    end
    ifc.btn_next_n = 1'b1;
    wait_clks(12);
    n_cmp++;
    if (ifc.code_out !== 8'h02 || ifc.pos !== 4'd2) begin
      n_bad++;
      $display("FAIL bounce_single: code=%h pos=%0d required code=02 pos=2", ifc.code_out, ifc.pos);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [9];
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(1'b1, 1'b0, 10);
      n_cmp++;
      if (ifc.code_out !== exp_seq[i] || ifc.pos !== 4'((i + 1) % 9)) begin
        n_bad++;
        $display("FAIL seq_next i=%0d: code=%h pos=%0d required code=%h pos=%0d",
                 i, ifc.code_out, ifc.pos, exp_seq[i], (i + 1) % 9);
      end
    end
    press(1'b0, 1'b1, 10);
    n_cmp++;
    if (ifc.code_out !== 8'h80 || ifc.pos !== 4'd8) begin
      n_bad++;
      $display("FAIL seq_prev_wrap: code=%h pos=%0d required code=80 pos=8", ifc.code_out, ifc.pos);
    end
  endtask

  task automatic test_both();
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10);
    n_cmp++;
    if (ifc.code_out !== 8'h04 || ifc.pos !== 4'd3) begin
      n_bad++;
      $display("FAIL both_setup: code=%h pos=%0d required code=04 pos=3", ifc.code_out, ifc.pos);
    end
    ifc.btn_next_n = 1'b0;
    ifc.btn_prev_n = 1'b0;
    for (int e = 0; e < 15; e++) begin
      step_clk();
      n_cmp++;
      if (ifc.code_out !== 8'h04 || ifc.pos !== 4'd3) begin
        n_bad++;
        $display("FAIL both_hold e=%0d: code=%h pos=%0d required code=04 pos=3", e, ifc.code_out, ifc.pos);
      end
    end
    ifc.btn_next_n = 1'b1;
    ifc.btn_prev_n = 1'b1;
    wait_clks(12);
    n_cmp++;
    if (ifc.code_out !== 8'h04 || ifc.pos !== 4'd3) begin
      n_bad++;
      $display("FAIL both_after: code=%h pos=%0d required code=04 pos=3", ifc.code_out, ifc.pos);
    end
  endtask

  task automatic test_auto();
    logic [7:0] exp;
    do_reset();
    ifc.auto_en = 1'b1;
    for (int e = 0; e <= 100; e++) begin
      step_clk();
      if      (e < 18) exp = 8'h00;
      else if (e < 34) exp = 8'h01;
      else if (e < 50) exp = 8'h02;
      else if (e < 66) exp = 8'h04;
      else if (e < 83) exp = 8'h08;
      else if (e < 99) exp = 8'h10;
      else             exp = 8'h20;
      n_cmp++;
      if (ifc.code_out !== exp) begin
        n_bad++;
        $display("FAIL auto e=%0d: code=%h required %h", e, ifc.code_out, exp);
      end
      if (e == 58) ifc.btn_next_n = 1'b0;
      if (e == 68) ifc.btn_next_n = 1'b1;
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (ifc.code_out !== 8'h00 || ifc.pos !== 4'd0) begin
      n_bad++;
      $display("FAIL auto_async_reset: code=%h pos=%0d required code=00 pos=0", ifc.code_out, ifc.pos);
    end
    ifc.auto_en = 1'b0;
    step_clk();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_debounce();
    logic [7:0] exp;
    do_reset();
    ifc.btn_next_n = 1'b0;
    wait_clks(4);
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    for (int e = 0; e < 13; e++) begin
      step_clk();
      exp = (e >= 7) ? 8'h01 : 8'h00;
      n_cmp++;
      if (ifc.code_out !== exp) begin
        n_bad++;
        $display("FAIL reset_mid_deb e=%0d: code=%h required %h", e, ifc.code_out, exp);
      end
    end
    ifc.btn_next_n = 1'b1;
    wait_clks(12);
    n_cmp++;
    if (ifc.code_out !== 8'h01 || ifc.pos !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_mid_deb_single: code=%h pos=%0d required code=01 pos=1", ifc.code_out, ifc.pos);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    ifc.btn_next_n = 1'b1;
    ifc.btn_prev_n = 1'b1;
    ifc.auto_en    = 1'b0;
    test_reset();
    test_hold_next();
    test_bounce();
    test_sequence();
    test_both();
    test_auto();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
